cycle_sequencer: RTL and testbench

//  Timing and instruction-cycle controller for the 4004 core. Generates the
//  one-hot 8-phase strobes (A1 A2 A3 M1 M2 X1 X2 X3) and SYNC. Sequences
//  two-cycle instructions: JUN/JMS/FIM second word, and FIN's indirect-fetch

---
 rtl/cycle_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_cycle_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cycle_sequencer
//
// Timing and instruction-cycle controller for the 4004 core. Walks an
// eight-phase ring (A1 A2 A3 M1 M2 X1 X2 X3) and raises one strobe per clock.
// It flags the clock before every A1 with SYNC. It also tracks two-cycle
// instructions: JUN/JMS/FIM carry a second word, and FIN needs an
// indirect-fetch cycle.
//
// Parameters
//   STARTUP_CYCLES  idle clocks after reset release before the first A1 (>=1)
//
// Ports
//   CLK           in   system clock, all state changes on the rising edge
//   RES           in   asynchronous active-high reset
//   RUN_EN        in   run permit, looked at only in X3 and IDLE
//   dec_two_word  in   decoder: opcode has a second word, looked at in X2
//   dec_fin       in   decoder: opcode is FIN, looked at in X2
//   A1..X3        out  one-hot phase strobes, all low in IDLE
//   SYNC          out  high in the clock immediately before every A1
//   second_cyc    out  this instruction cycle carries a second word
//   do_fin        out  this instruction cycle is FIN's indirect fetch
//   pc_inc        out  one-clock pulse in X3, PC advances at end of cycle
//   idle          out  sequencer is parked in IDLE
// ---------------------------------------------------------------------------
module cycle_sequencer #(
    parameter int STARTUP_CYCLES = 2
) (
    input  logic CLK,
    input  logic RES,
    input  logic RUN_EN,
    input  logic dec_two_word,
    input  logic dec_fin,
    output logic A1,
    output logic A2,
    output logic A3,
    output logic M1,
    output logic M2,
    output logic X1,
    output logic X2,
    output logic X3,
    output logic SYNC,
    output logic second_cyc,
    output logic do_fin,
    output logic pc_inc,
    output logic idle
);

    localparam int CNT_W = $clog2(STARTUP_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STARTUP_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A1,
        ST_A2,
        ST_A3,
        ST_M1,
        ST_M2,
        ST_X1,
        ST_X2,
        ST_X3
    } state_e;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] startCnt_q,  startCnt_d;
    logic             pendTwo_q,   pendTwo_d;
    logic             pendFin_q,   pendFin_d;
    logic             secondCyc_q, secondCyc_d;
    logic             doFin_q,     doFin_d;
    logic [7:0]       phase_q,     phase_d;
    logic             pcInc_q,     pcInc_d;
    logic             idle_q,      idle_d;
    logic             goA1;

    // Next-state logic for the phase ring, the startup counter and the
    // two-cycle bookkeeping. goA1 marks every clock whose successor is A1,
    // and SYNC is built from it.
    always_comb begin
        state_d     = state_q;
        startCnt_d  = startCnt_q;
        pendTwo_d   = pendTwo_q;
        pendFin_d   = pendFin_q;
        secondCyc_d = secondCyc_q;
        doFin_d     = doFin_q;
        goA1        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The counter runs down first and then holds at zero. Only
                // at zero does RUN_EN start the ring.
                if (startCnt_q != '0) begin
                    startCnt_d = startCnt_q - CNT_W'(1);
                end else if (RUN_EN) begin
                    state_d = ST_A1;
                    goA1    = 1'b1;
                end
            end
            ST_A1: state_d = ST_A2;
            ST_A2: state_d = ST_A3;
            ST_A3: state_d = ST_M1;
            ST_M1: state_d = ST_M2;
            ST_M2: state_d = ST_X1;
            ST_X1: state_d = ST_X2;
            ST_X2: begin
                state_d = ST_X3;
                // In a second-word cycle the fetched byte is data. The
                // decoder's view of it must not start another cycle.
                if (!secondCyc_q && !doFin_q) begin
                    pendTwo_d = dec_two_word | dec_fin;
                    pendFin_d = dec_fin;
                end
            end
            ST_X3: begin
                secondCyc_d = pendTwo_q;
                doFin_d     = pendFin_q;
                pendTwo_d   = 1'b0;
                pendFin_d   = 1'b0;
                // A pending second cycle always runs, whatever RUN_EN says.
                // Parking leaves the counter at zero so the next RUN_EN
                // restarts at once.
                if (RUN_EN || pendTwo_q) begin
                    state_d = ST_A1;
                    goA1    = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                    startCnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                startCnt_d = '0;
            end
        endcase
    end

    // Registered output decodes. They are taken from the next state so that
    // the strobes line up with the state register.
    always_comb begin
        phase_d = 8'h00;
        case (state_d)
            ST_A1:   phase_d = 8'b1000_0000;
            ST_A2:   phase_d = 8'b0100_0000;
            ST_A3:   phase_d = 8'b0010_0000;
            ST_M1:   phase_d = 8'b0001_0000;
            ST_M2:   phase_d = 8'b0000_1000;
            ST_X1:   phase_d = 8'b0000_0100;
            ST_X2:   phase_d = 8'b0000_0010;
            ST_X3:   phase_d = 8'b0000_0001;
            default: phase_d = 8'h00;
        endcase
        // The PC holds in FIN's fetch cycle. The register pair drives the
        // ROM address there, so the PC still points at the FIN.
        pcInc_d = (state_q == ST_X2) && !doFin_q;
        idle_d  = (state_d == ST_IDLE);
    end

    // All sequencer state lives in this one block. Reset is asynchronous
    // and may arrive mid-phase. It parks the ring in IDLE and reloads the
    // startup delay.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q     <= ST_IDLE;
            startCnt_q  <= CNT_INIT;
            pendTwo_q   <= 1'b0;
            pendFin_q   <= 1'b0;
            secondCyc_q <= 1'b0;
            doFin_q     <= 1'b0;
            phase_q     <= 8'h00;
            pcInc_q     <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            startCnt_q  <= startCnt_d;
            pendTwo_q   <= pendTwo_d;
            pendFin_q   <= pendFin_d;
            secondCyc_q <= secondCyc_d;
            doFin_q     <= doFin_d;
            phase_q     <= phase_d;
            pcInc_q     <= pcInc_d;
            idle_q      <= idle_d;
        end
    end

    // SYNC follows RUN_EN within the same clock, so it has to be
    // combinational. It is held low while reset is asserted.
    assign SYNC = goA1 & ~RES;

    assign {A1, A2, A3, M1, M2, X1, X2, X3} = phase_q;
    assign second_cyc = secondCyc_q;
    assign do_fin     = doFin_q;
    assign pc_inc     = pcInc_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cycle_sequencer
//
// Self-checking bench for cycle_sequencer with STARTUP_CYCLES = 2.
// A hand-written vector table covers startup, two-word cycles, the FIN fetch
// cycle and parking. Hand sequences cover an asynchronous reset in the middle
// of a FIN cycle. A randomised run is then compared against a cycle-level
// reference model.
// ---------------------------------------------------------------------------
module tb_cycle_sequencer;

    localparam int STARTUP = 2;

    logic CLK = 1'b0;
    logic RES;
    logic runEn;
    logic decTwo;
    logic decFin;
    logic A1, A2, A3, M1, M2, X1, X2, X3;
    logic SYNC, second_cyc, do_fin, pc_inc, idle;
    logic [12:0] dutVec;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state. mPh holds 0..7 for A1..X3 and 8 for idle.
    int mPh;
    int mWait;
    bit mP2, mPf, mSec, mFin;

    typedef struct {
        logic run;
        logic two;
        logic fin;
        int   ph;
        logic sync;
        logic sec;
        logic dofin;
        logic pc;
    } vec_t;

    vec_t vecs[$];

    cycle_sequencer #(.STARTUP_CYCLES(STARTUP)) dut (
        .CLK          (CLK),
        .RES          (RES),
        .RUN_EN       (runEn),
        .dec_two_word (decTwo),
        .dec_fin      (decFin),
        .A1           (A1),
        .A2           (A2),
        .A3           (A3),
        .M1           (M1),
        .M2           (M2),
        .X1           (X1),
        .X2           (X2),
        .X3           (X3),
        .SYNC         (SYNC),
        .second_cyc   (second_cyc),
        .do_fin       (do_fin),
        .pc_inc       (pc_inc),
        .idle         (idle)
    );

    assign dutVec = {A1, A2, A3, M1, M2, X1, X2, X3, SYNC, second_cyc, do_fin, pc_inc, idle};

    // 10 ns clock period
    always #5 CLK = ~CLK;

    // Stop a stuck run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Builds an output vector from a phase index and the flag values.
    function automatic logic [12:0] buildVec(input int ph, input logic sy, input logic sec,
                                             input logic fin, input logic pc);
        logic [7:0] s;
        s = (ph < 8) ? (8'h80 >> ph) : 8'h00;
        return {s, sy, sec, fin, pc, (ph == 8)};
    endfunction

    function automatic logic [12:0] modelExpect(input logic run);
        logic sy;
        sy = (mPh == 8 && mWait == 0 && run) || (mPh == 7 && (run || mP2));
        return buildVec(mPh, sy, mSec, mFin, (mPh == 7) && !mFin);
    endfunction

    task automatic modelReset();
        mPh   = 8;
        mWait = STARTUP - 1;
        mP2   = 0;
        mPf   = 0;
        mSec  = 0;
        mFin  = 0;
    endtask

    // Advances the model by one clock, using the inputs held during that clock.
    task automatic modelStep();
        bit cont;
        if (mPh == 8) begin
            if (mWait > 0) mWait--;
            else if (runEn) mPh = 0;
        end else if (mPh == 7) begin
            cont = runEn || mP2;
            mSec = mP2;
            mFin = mPf;
            mP2  = 0;
            mPf  = 0;
            if (cont) mPh = 0;
            else begin
                mPh   = 8;
                mWait = 0;
            end
        end else begin
            if (mPh == 6 && !mSec) begin
                mP2 = decTwo || decFin;
                mPf = decFin;
            end
            mPh++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [12:0] actual, input logic [12:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    endtask

    // Properties that must hold in every clock, whatever the inputs
    task automatic checkInvariants();
        logic ok;
        logic [7:0] s;
        s  = dutVec[12:5];
        ok = $onehot0(s) && ((s == 8'h00) == idle) && (!SYNC || X3 || idle) && (!pc_inc || X3);
        checkOutput("invariants", {12'b0, ok}, 13'd1);
    endtask

    // One clock: the model advances at the edge, new inputs go in at +1
    // and the outputs are compared at +2.
    task automatic applyStimulus(input logic run, input logic two, input logic fin);
        @(posedge CLK);
        if (!RES) modelStep();
        #1;
        runEn  = run;
        decTwo = two;
        decFin = fin;
        #1;
        checkOutput("model", dutVec, modelExpect(runEn));
        checkInvariants();
    endtask

    // Reset pulse that opens and closes between two clock edges
    task automatic pulseReset(input string name);
        #1 RES = 1'b1;
        #1;
        modelReset();
        checkOutput(name, dutVec, 13'h001);
        checkOutput({name, " model"}, dutVec, modelExpect(runEn));
        #1 RES = 1'b0;
    endtask

    task automatic addRow(input logic run, input logic two, input logic fin, input int ph,
                          input logic sy, input logic sec, input logic dofin, input logic pc);
        vec_t v;
        v.run = run; v.two = two; v.fin = fin; v.ph = ph;
        v.sync = sy; v.sec = sec; v.dofin = dofin; v.pc = pc;
        vecs.push_back(v);
    endtask

    // One full A1..X3 cycle. decode inputs apply in X2 and SYNC in X3.
    task automatic addCycle(input logic sec, input logic dofin, input logic twoX2, input logic finX2,
                            input logic run, input logic syncX3);
        for (int p = 0; p < 8; p++)
            addRow(run, (p == 6) ? twoX2 : 1'b0, (p == 6) ? finX2 : 1'b0, p,
                   (p == 7) ? syncX3 : 1'b0, sec, dofin, (p == 7) ? !dofin : 1'b0);
    endtask

    initial begin
        logic reached;

        // Startup, then three two-cycle cases and parking
        addRow(1, 0, 0, 8, 1, 0, 0, 0);
        addCycle(0, 0, 1, 0, 1, 1);
        addCycle(1, 0, 1, 0, 1, 1);
        addCycle(0, 0, 0, 1, 1, 1);
        addCycle(1, 1, 0, 0, 0, 0);
        addRow(0, 0, 0, 8, 0, 0, 0, 0);
        addRow(0, 0, 0, 8, 0, 0, 0, 0);
        addRow(1, 0, 0, 8, 1, 0, 0, 0);
        addCycle(0, 0, 1, 0, 0, 1);
        addCycle(1, 0, 0, 0, 0, 0);
        addRow(0, 0, 0, 8, 0, 0, 0, 0);
        addRow(0, 0, 0, 8, 0, 0, 0, 0);

        RES    = 1'b1;
        runEn  = 1'b0;
        decTwo = 1'b0;
        decFin = 1'b0;
        modelReset();

        @(posedge CLK);
        #1 checkOutput("in reset", dutVec, 13'h001);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RES   = 1'b0;
        runEn = 1'b1;
        #1;
        checkOutput("release idle", dutVec, 13'h001);
        checkOutput("release model", dutVec, modelExpect(runEn));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].run, vecs[i].two, vecs[i].fin);
            checkOutput($sformatf("vector %0d", i), dutVec,
                        buildVec(vecs[i].ph, vecs[i].sync, vecs[i].sec, vecs[i].dofin, vecs[i].pc));
        end

        // Run until the M2 of a FIN fetch cycle and reset it there.
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            applyStimulus(1, 0, 1);
            if (M2 && do_fin && second_cyc) reached = 1'b1;
        end
        checkOutput("reach fin M2", {12'b0, reached}, 13'd1);
        pulseReset("reset mid fin");
        applyStimulus(1, 0, 0);
        checkOutput("restart sync", dutVec, {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        applyStimulus(1, 0, 0);
        checkOutput("restart A1", dutVec, {8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Random traffic, with an occasional asynchronous reset
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 99) == 0) pulseReset("random reset");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
